cmd_parser: RTL

CMD_PARSER -- requirements
Module: cmd_parser

---
 rtl/cmd_parser.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/cmd_parser.sv
// cmd_parser: ASCII command line parser.
// Accepts lines of the form <type><operand1><op><operand2><CR>, where type is
// 's' (signed) or 'u' (unsigned), operands are decimal with an optional
// leading '-' in signed mode, and op is one of + - * /.
// Ports:
//   clk, n_rst       clock, asynchronous active-low reset
//   rx_data/rx_valid byte stream from a UART receiver (no backpressure)
//   dtype            4'h1 signed, 4'h2 unsigned, 4'h0 none
//   operator         5'h01 '+', 5'h02 '-', 5'h03 '*', 5'h04 '/'
//   src1, src2       operands (two's complement when signed)
//   parser_done      one-cycle pulse, command fields updated
//   parse_err        one-cycle pulse, line rejected
//   busy             a line is partially received
module cmd_parser #(
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [3:0]  dtype,
    output logic [4:0]  operator,
    output logic [15:0] src1,
    output logic [15:0] src2,
    output logic        parser_done,
    output logic        parse_err,
    output logic        busy
);

    localparam int unsigned ACC_W  = 17;
    // Wide enough for 65535*10+9 before the range check discards it.
    localparam int unsigned CALC_W = 20;
    localparam int unsigned CNT_W  = $clog2(MAX_DIGITS + 1);

    localparam logic [CALC_W-1:0] LIM_U   = CALC_W'(65535);
    localparam logic [CALC_W-1:0] LIM_POS = CALC_W'(32767);
    localparam logic [CALC_W-1:0] LIM_NEG = CALC_W'(32768);

    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;
    localparam logic [7:0] CH_S     = 8'h73;
    localparam logic [7:0] CH_U     = 8'h75;

    typedef enum logic [1:0] {
        S_TYPE,
        S_NUM1,
        S_NUM2,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               sgn_q, sgn_d;
    logic [4:0]         op_q, op_d;
    logic [15:0]        op1_q, op1_d;
    logic [3:0]         dtype_d;
    logic [4:0]         operator_d;
    logic [15:0]        src1_d, src2_d;
    logic               done_d, err_d;

    logic               is_digit;
    logic [4:0]         op_code;
    logic [CALC_W-1:0]  acc_ext, acc_next, limit;
    logic               digit_ok;
    logic [15:0]        opnd;

    // Operator character to output code; zero for non-operators.
    function automatic logic [4:0] decode_op(input logic [7:0] c);
        case (c)
            8'h2B:   decode_op = 5'h01;
            8'h2D:   decode_op = 5'h02;
            8'h2A:   decode_op = 5'h03;
            8'h2F:   decode_op = 5'h04;
            default: decode_op = 5'h00;
        endcase
    endfunction

    // Character classification and the candidate accumulator value.
    assign is_digit = (rx_data >= CH_ZERO) && (rx_data <= CH_NINE);
    assign op_code  = decode_op(rx_data);
    assign acc_ext  = CALC_W'(acc_q);
    assign acc_next = (acc_ext << 3) + (acc_ext << 1) + CALC_W'(rx_data[3:0]);
    assign limit    = sgn_q ? (neg_q ? LIM_NEG : LIM_POS) : LIM_U;
    // Range is checked on every digit so the accumulator never exceeds 16 bits.
    assign digit_ok = (cnt_q < CNT_W'(MAX_DIGITS)) && (acc_next <= limit);
    // -32768 comes out as 0x8000 because the magnitude fits in 16 bits.
    assign opnd     = neg_q ? (~acc_q[15:0] + 16'd1) : acc_q[15:0];

    // State and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_TYPE;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            sgn_q       <= 1'b0;
            op_q        <= '0;
            op1_q       <= '0;
            dtype       <= '0;
            operator    <= '0;
            src1        <= '0;
            src2        <= '0;
            parser_done <= 1'b0;
            parse_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            sgn_q       <= sgn_d;
            op_q        <= op_d;
            op1_q       <= op1_d;
            dtype       <= dtype_d;
            operator    <= operator_d;
            src1        <= src1_d;
            src2        <= src2_d;
            parser_done <= done_d;
            parse_err   <= err_d;
            busy        <= (state_d != S_TYPE);
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        sgn_d      = sgn_q;
        op_d       = op_q;
        op1_d      = op1_q;
        dtype_d    = dtype;
        operator_d = operator;
        src1_d     = src1;
        src2_d     = src2;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (rx_valid && (rx_data != CH_SP)) begin
            case (state_q)
                S_TYPE: begin
                    if ((rx_data == CH_S) || (rx_data == CH_U)) begin
                        sgn_d   = (rx_data == CH_S);
                        acc_d   = '0;
                        cnt_d   = '0;
                        neg_d   = 1'b0;
                        state_d = S_NUM1;
                    end else if ((rx_data != CH_CR) && (rx_data != CH_LF)) begin
                        state_d = S_ERR;
                    end
                end

                S_NUM1, S_NUM2: begin
                    if (is_digit) begin
                        if (digit_ok) begin
                            acc_d = ACC_W'(acc_next);
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if (cnt_q == '0) begin
                        // Only a single sign is allowed ahead of the digits.
                        if ((rx_data == CH_MINUS) && sgn_q && !neg_q) begin
                            neg_d = 1'b1;
                        end else if (rx_data == CH_CR) begin
                            err_d   = 1'b1;
                            state_d = S_TYPE;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if ((state_q == S_NUM1) && (op_code != '0)) begin
                        op_d    = op_code;
                        op1_d   = opnd;
                        acc_d   = '0;
                        cnt_d   = '0;
                        neg_d   = 1'b0;
                        state_d = S_NUM2;
                    end else if ((state_q == S_NUM2) && (rx_data == CH_CR)) begin
                        dtype_d    = sgn_q ? 4'h1 : 4'h2;
                        operator_d = op_q;
                        src1_d     = op1_q;
                        src2_d     = opnd;
                        done_d     = 1'b1;
                        state_d    = S_TYPE;
                    end else if (rx_data == CH_CR) begin
                        err_d   = 1'b1;
                        state_d = S_TYPE;
                    end else begin
                        state_d = S_ERR;
                    end
                end

                S_ERR: begin
                    if (rx_data == CH_CR) begin
                        err_d   = 1'b1;
                        state_d = S_TYPE;
                    end
                end

                default: state_d = S_TYPE;
            endcase
        end
    end

endmodule
